mem_resp_ctrl: RTL and testbench

Memory-side responder for the cache write-back/write-allocate sequencer's memory interface. It accepts single-word read/write requests, stalls the requester by holding mem_miss high for a fixed LATENCY, then completes with one mem_miss-low cycle carrying read data. It contains a word-addressed backing store and acts as main memory for scalar-core cache simulation and synthesis.

---
 rtl/mem_resp_ctrl.sv | 116 +++++++++++
 tb/tb_mem_resp_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_resp_ctrl.sv
// Word-addressed backing store that stalls each request for LATENCY cycles, then completes with a one-cycle strobe.
// Optional `MEM_RESP_POSTED_WR_EN: when defined, writes complete in their request cycle and reads are unaffected.
module mem_resp_ctrl #(
    parameter int LATENCY  = 4,
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_ctl_we,
    input  logic [31:0] mem_wdata,
    output logic        mem_miss,
    output logic [31:0] mem_rdata,
    output logic        mem_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [IDX_W-1:0] lat_idx, req_idx, rd_idx;
    logic             lat_we;
    logic [31:0]      lat_wdata;
    logic             latch, rd_load, posted_wr;
    logic [31:0]      store [DEPTH];
    logic             unused_addr;

    assign unused_addr = ^mem_addr;
    assign req_idx     = mem_addr[ADDR_LSB +: IDX_W];

`ifdef MEM_RESP_POSTED_WR_EN
    assign posted_wr = (state == IDLE) && mem_req && mem_ctl_we;
`else
    assign posted_wr = 1'b0;
`endif

    // With LATENCY==1 the read happens on the request edge, before the latches hold the address.
    assign rd_idx = (state == IDLE) ? req_idx : lat_idx;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mem_miss  = 1'b0;
        mem_done  = 1'b0;
        latch     = 1'b0;
        rd_load   = 1'b0;
        case (state)
            IDLE: begin
                if (posted_wr) begin
                    mem_done = 1'b1;
                end else if (mem_req) begin
                    mem_miss = 1'b1;
                    latch    = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = DONE;
                        rd_load   = !mem_ctl_we;
                    end else begin
                        count_nxt = CNT_W'(LATENCY - 2);
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_miss = 1'b1;
                if (count == '0) begin
                    state_nxt = DONE;
                    rd_load   = !lat_we;
                end else begin
                    count_nxt = count - CNT_W'(1);
                end
            end
            DONE: begin
                mem_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            mem_rdata <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (latch) begin
                lat_idx   <= req_idx;
                lat_we    <= mem_ctl_we;
                lat_wdata <= mem_wdata;
            end
            if (rd_load) begin
                mem_rdata <= store[rd_idx];
            end
        end
    end

    // Store is not reset; an aborted request never reaches DONE, so it never writes.
    always_ff @(posedge clock) begin
        if (state == DONE && lat_we) begin
            store[lat_idx] <= lat_wdata;
        end else if (posted_wr) begin
            store[req_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed bench: instance a uses LATENCY=4, instance b uses LATENCY=1.
module tb_mem_resp_ctrl;

`ifdef MEM_RESP_POSTED_WR_EN
    localparam int WR_MISS_A = 0;
    localparam int WR_MISS_B = 0;
`else
    localparam int WR_MISS_A = 4;
    localparam int WR_MISS_B = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [31:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
    logic        miss_a, done_a, miss_b, done_b;
    logic [31:0] rdata_a, rdata_b;

    int vectors    = 0;
    int miscompares = 0;

    int          mc;
    logic [31:0] rd;
    logic        dn;

    always #5 clock = ~clock;

    mem_resp_ctrl #(.LATENCY(4), .DEPTH(1024), .ADDR_LSB(2)) dut_a (
        .clock(clock), .reset(reset), .mem_req(req_a), .mem_addr(addr_a),
        .mem_ctl_we(we_a), .mem_wdata(wdata_a), .mem_miss(miss_a),
        .mem_rdata(rdata_a), .mem_done(done_a)
    );

    mem_resp_ctrl #(.LATENCY(1), .DEPTH(1024), .ADDR_LSB(2)) dut_b (
        .clock(clock), .reset(reset), .mem_req(req_b), .mem_addr(addr_b),
        .mem_ctl_we(we_b), .mem_wdata(wdata_b), .mem_miss(miss_b),
        .mem_rdata(rdata_b), .mem_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for its completion strobe, counting stall cycles.
    task automatic xfer(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int miss_cycles,
                        output logic [31:0] rdata, output logic done_ok);
        @(negedge clock);
        if (sel) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
        else     begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
        miss_cycles = 0;
        done_ok     = 1'b0;
        rdata       = '0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (sel ? done_b : done_a) begin
                rdata   = sel ? rdata_b : rdata_a;
                done_ok = 1'b1;
                break;
            end
            if (sel ? miss_b : miss_a) miss_cycles++;
            @(negedge clock);
        end
        if (sel) req_b = 1'b0; else req_a = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_miss;
        logic [9:0] exp_done;
        exp_miss = 10'b1111011110;
        exp_done = 10'b0000100001;

        repeat (3) @(negedge clock);
        #1;
        check("rst_miss", 32'(miss_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("post_rst_miss", 32'(miss_a), 32'd0);
        check("post_rst_done", 32'(done_a), 32'd0);

        xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, mc, rd, dn);
        check("wr10_done", 32'(dn), 32'd1);
        check("wr10_miss", 32'(mc), 32'(WR_MISS_A));
        check("wr10_rdata_held", rd, 32'd0);
        xfer(1'b0, 1'b0, 32'h10, 32'h0, mc, rd, dn);
        check("rd10_miss", 32'(mc), 32'd4);
        check("rd10_data", rd, 32'hDEADBEEF);

        xfer(1'b0, 1'b1, 32'h1000, 32'h1, mc, rd, dn);
        check("wr1000_rdata_held", rd, 32'hDEADBEEF);
        xfer(1'b0, 1'b0, 32'h0, 32'h0, mc, rd, dn);
        check("rd0_wrap", rd, 32'h1);

        // Back-to-back reads with req held high: one miss-low DONE cycle separates them.
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h13;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("b2b_miss_%0d", i), 32'(miss_a), 32'(exp_miss[9-i]));
            check($sformatf("b2b_done_%0d", i), 32'(done_a), 32'(exp_done[9-i]));
            @(negedge clock);
        end
        req_a = 1'b0;
        check("b2b_data", rdata_a, 32'hDEADBEEF);

        xfer(1'b1, 1'b1, 32'h0, 32'h12345678, mc, rd, dn);
        check("b_wr_miss", 32'(mc), 32'(WR_MISS_B));
        xfer(1'b1, 1'b0, 32'h0, 32'h0, mc, rd, dn);
        check("b_rd_miss", 32'(mc), 32'd1);
        check("b_rd_data", rd, 32'h12345678);

`ifndef MEM_RESP_POSTED_WR_EN
        // Address/data changed during BUSY must not affect the latched write.
        xfer(1'b0, 1'b1, 32'h24, 32'h11111111, mc, rd, dn);
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h20; wdata_a = 32'hA5A5A5A5;
        @(negedge clock);
        addr_a = 32'h24; wdata_a = 32'h22222222;
        repeat (4) @(negedge clock);
        req_a = 1'b0;
        xfer(1'b0, 1'b0, 32'h20, 32'h0, mc, rd, dn);
        check("busy_chg_20", rd, 32'hA5A5A5A5);
        xfer(1'b0, 1'b0, 32'h24, 32'h0, mc, rd, dn);
        check("busy_chg_24", rd, 32'h11111111);

        // Dropping req mid-BUSY still completes the write.
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h40; wdata_a = 32'hCAFE0001;
        @(negedge clock);
        req_a = 1'b0;
        repeat (4) @(negedge clock);
        xfer(1'b0, 1'b0, 32'h40, 32'h0, mc, rd, dn);
        check("drop_req_wr", rd, 32'hCAFE0001);

        // Reset mid-BUSY aborts the write.
        xfer(1'b0, 1'b1, 32'h30, 32'h13579BDF, mc, rd, dn);
        @(negedge clock);
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'h30; wdata_a = 32'hFFFFFFFF;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        req_a = 1'b0;
        #1;
        check("abort_miss", 32'(miss_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_rdata", rdata_a, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        xfer(1'b0, 1'b0, 32'h30, 32'h0, mc, rd, dn);
        check("abort_no_write", rd, 32'h13579BDF);
`else
        xfer(1'b0, 1'b1, 32'h8, 32'h5555AAAA, mc, rd, dn);
        check("posted_miss", 32'(mc), 32'd0);
        check("posted_done", 32'(dn), 32'd1);
        xfer(1'b0, 1'b0, 32'h8, 32'h0, mc, rd, dn);
        check("posted_rd_miss", 32'(mc), 32'd4);
        check("posted_rd_data", rd, 32'h5555AAAA);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
